audio_mix_seq: RTL and testbench

- Time-multiplexed audio mixer and sequencer that feeds the delta-sigma DAC input word.
- On each sample strobe it latches CHANNELS signed sources and their volumes. It then runs them one per clock through a single shared multiply-accumulate, saturates the sum, and presents the result in excess-2^(OW-1) format.
- Sits between the sound sources (beeper, PSG, tape) and the DAC. Its output connects directly to the DAC `d` input.

---
 rtl/audio_pkg.sv | 50 +++++
 rtl/audio_mix_seq_if.sv | 32 +++
 rtl/audio_mac.sv | 34 +++
 rtl/audio_mix_seq.sv | 130 +++++++++++++
 tb/tb_audio_mix_seq.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio mixer: volume format, FSM state
// encoding and the saturating excess-code converter.
package audio_pkg;

  localparam int VOL_W     = 4;
  localparam int VOL_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  typedef struct packed {
    logic        clip;
    logic [31:0] word;
  } sat_t;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

  // word[ow-1:0] is the saturated, scaled sum with its MSB inverted;
  // the bits above ow are don't-care for the caller.
  function automatic sat_t sat_to_excess(input logic signed [31:0] acc, input int ow);
    logic signed [31:0] scaled;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] lim;
    sat_t               r;
    scaled = acc >>> VOL_SHIFT;
    hi     = (32'sd1 <<< (ow - 1)) - 32'sd1;
    lo     = -(32'sd1 <<< (ow - 1));
    r.clip = 1'b0;
    lim    = scaled;
    if (scaled > hi) begin
      lim    = hi;
      r.clip = 1'b1;
    end else if (scaled < lo) begin
      lim    = lo;
      r.clip = 1'b1;
    end
    r.word = lim ^ (32'sd1 <<< (ow - 1));
    return r;
  endfunction

endpackage

// File: rtl/audio_mix_seq_if.sv
// Source-side bundle of the audio mixer: sample strobe, channel inputs,
// flag clear, and the DAC word with its status outputs.
interface audio_mix_seq_if
  import audio_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int IW       = 8,
  parameter int OW       = 8
);

  logic                      ce_sample;
  logic [CHANNELS*IW-1:0]    ch_data;
  logic [CHANNELS*VOL_W-1:0] ch_vol;
  logic [CHANNELS-1:0]       ch_mute;
  logic                      clr_flags;
  logic [OW-1:0]             d;
  logic                      d_valid;
  logic                      busy;
  logic                      clip;
  logic                      overrun;

  modport master (
    output ce_sample, ch_data, ch_vol, ch_mute, clr_flags,
    input  d, d_valid, busy, clip, overrun
  );

  modport slave (
    input  ce_sample, ch_data, ch_vol, ch_mute, clr_flags,
    output d, d_valid, busy, clip, overrun
  );

endinterface

// File: rtl/audio_mac.sv
// Registered signed multiply-accumulate: acc += sample * unsigned volume,
// with synchronous clear and enable.
module audio_mac
  import audio_pkg::*;
#(
  parameter int IW = 8,
  parameter int AW = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [IW-1:0] sample_i,
  input  logic [VOL_W-1:0]     vol_i,
  output logic signed [AW-1:0] acc_o
);

  logic signed [IW+VOL_W:0] prod;
  logic signed [AW-1:0]     acc_q;

  // Volume is zero-extended so 15 stays positive in the signed product.
  assign prod  = sample_i * $signed({1'b0, vol_i});
  assign acc_o = acc_q;

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + AW'(prod);
    end
  end

endmodule

// File: rtl/audio_mix_seq.sv
// Time-multiplexed audio mixer: latches all channels on ce_sample, runs them
// through one shared MAC, saturates, and drives the DAC in excess code.
module audio_mix_seq
  import audio_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int IW       = 8,
  parameter int OW       = 8
) (
  input logic            clock,
  input logic            reset,
  audio_mix_seq_if.slave mix
);

  localparam int IDXW = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
  localparam int AW   = IW + VOL_W + 1 + clog2(CHANNELS);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ACC  = ACC;
  localparam logic [1:0] S_OUT  = OUT;

  logic [1:0]                state_q, state_d;
  logic [IDXW-1:0]           idx_q, idx_d;
  logic [OW-1:0]             d_q, d_d;
  logic                      d_valid_q, d_valid_d;
  logic                      clip_q, clip_d;
  logic                      overrun_q, overrun_d;
  logic [CHANNELS*IW-1:0]    data_q;
  logic [CHANNELS*VOL_W-1:0] vol_q;
  logic [CHANNELS-1:0]       mute_q;

  logic                      start;
  logic                      last;
  logic signed [IW-1:0]      cur_sample;
  logic [VOL_W-1:0]          cur_vol;
  logic signed [AW-1:0]      acc;
  sat_t                      sat;
  logic                      unused_sat;

  assign start      = (state_q == S_IDLE) && mix.ce_sample;
  assign last       = (idx_q == IDXW'(CHANNELS - 1));
  assign cur_sample = data_q[idx_q*IW +: IW];
  assign cur_vol    = mute_q[idx_q] ? '0 : vol_q[idx_q*VOL_W +: VOL_W];

  audio_mac #(
    .IW (IW),
    .AW (AW)
  ) u_mac (
    .clock    (clock),
    .reset    (reset),
    .clr_i    (start),
    .en_i     (state_q == S_ACC),
    .sample_i (cur_sample),
    .vol_i    (cur_vol),
    .acc_o    (acc)
  );

  assign sat        = sat_to_excess(32'(acc), OW);
  assign unused_sat = ^sat.word[31:OW];

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    d_d       = d_q;
    d_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mix.ce_sample) begin
          state_d = S_ACC;
          idx_d   = '0;
        end
      end
      S_ACC: begin
        idx_d = last ? '0 : idx_q + 1'b1;
        if (last) state_d = S_OUT;
      end
      S_OUT: begin
        d_d       = sat.word[OW-1:0];
        d_valid_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Set beats clear when both land in the same cycle.
    clip_d    = clip_q;
    overrun_d = overrun_q;
    if (mix.clr_flags) begin
      clip_d    = 1'b0;
      overrun_d = 1'b0;
    end
    if (state_q == S_OUT && sat.clip) clip_d = 1'b1;
    if (mix.ce_sample && state_q != S_IDLE) overrun_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      d_q       <= OW'(1) << (OW - 1);
      d_valid_q <= 1'b0;
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      d_q       <= d_d;
      d_valid_q <= d_valid_d;
      clip_q    <= clip_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: shadow registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clock) begin
    if (start) begin
      data_q <= mix.ch_data;
      vol_q  <= mix.ch_vol;
      mute_q <= mix.ch_mute;
    end
  end

  assign mix.d       = d_q;
  assign mix.d_valid = d_valid_q;
  assign mix.busy    = (state_q != S_IDLE);
  assign mix.clip    = clip_q;
  assign mix.overrun = overrun_q;

endmodule

// File: tb/tb_audio_mix_seq.sv
// Self-checking bench for audio_mix_seq: reference mix pushed to a scoreboard
// at each accepted strobe, popped and compared on every d_valid.
module tb_audio_mix_seq;

  localparam int CH  = 4;
  localparam int IW  = 8;
  localparam int OW  = 8;
  localparam int LAT = CH + 1;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  logic clock;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  audio_mix_seq_if #(.CHANNELS(CH), .IW(IW), .OW(OW)) mix_if ();

  audio_mix_seq #(
    .CHANNELS (CH),
    .IW       (IW),
    .OW       (OW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .mix   (mix_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_mix(input logic [31:0] data, input logic [15:0] vol,
                                           input logic [3:0] mute);
    int sum;
    int scaled;
    sum = 0;
    for (int i = 0; i < CH; i++)
      if (!mute[i]) sum += int'($signed(data[i*8 +: 8])) * int'(vol[i*4 +: 4]);
    scaled = sum >>> 4;
    if (scaled > 127)  scaled = 127;
    if (scaled < -128) scaled = -128;
    return 8'(scaled + 128);
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic strobe(input bit accept);
    exp_t e;
    mix_if.ce_sample = 1'b1;
    tick();
    mix_if.ce_sample = 1'b0;
    if (accept) begin
      e.d   = model_mix(mix_if.ch_data, mix_if.ch_vol, mix_if.ch_mute);
      e.due = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("drain", sb.size(), 0);
  endtask

  task automatic clear_flags();
    mix_if.clr_flags = 1'b1;
    tick();
    mix_if.clr_flags = 1'b0;
  endtask

  // Output side of the scoreboard.
  always @(posedge clock) begin : mon
    exp_t e;
    #1;
    if (mix_if.d_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_d_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("d", mix_if.d, e.d);
        check("latency", cyc, e.due);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vectors          = 0;
    miscompares      = 0;
    reset            = 1'b1;
    mix_if.ce_sample = 1'b0;
    mix_if.ch_data   = '0;
    mix_if.ch_vol    = '0;
    mix_if.ch_mute   = '0;
    mix_if.clr_flags = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_d", mix_if.d, 8'h80);
    check("rst_d_valid", mix_if.d_valid, 0);
    check("rst_busy", mix_if.busy, 0);
    check("rst_clip", mix_if.clip, 0);
    check("rst_overrun", mix_if.overrun, 0);
    reset = 1'b0;
    tick();

    // Single channel, step by step through the pass.
    mix_if.ch_data = 32'h0000_0040;
    mix_if.ch_vol  = 16'h000F;
    strobe(1);
    check("busy_e1", mix_if.busy, 1);
    for (int k = 2; k <= LAT; k++) begin
      tick();
      check("busy_acc", mix_if.busy, 1);
      check("dv_early", mix_if.d_valid, 0);
    end
    tick();
    check("dv_out", mix_if.d_valid, 1);
    check("busy_out", mix_if.busy, 0);
    check("d_single", mix_if.d, 8'hBC);
    check("clip_single", mix_if.clip, 0);
    tick();
    check("dv_pulse", mix_if.d_valid, 0);
    tick();
    check("d_hold", mix_if.d, 8'hBC);

    // Positive then negative saturation, then clear.
    mix_if.ch_data = 32'h7F7F_7F7F;
    mix_if.ch_vol  = 16'hFFFF;
    strobe(1);
    wait_done();
    check("d_pos_sat", mix_if.d, 8'hFF);
    check("clip_pos", mix_if.clip, 1);
    mix_if.ch_data = 32'h8080_8080;
    strobe(1);
    wait_done();
    check("d_neg_sat", mix_if.d, 8'h00);
    check("clip_neg", mix_if.clip, 1);
    clear_flags();
    check("clip_clr", mix_if.clip, 0);

    // Mute and negative exactness.
    mix_if.ch_data = 32'h0000_7FC0;
    mix_if.ch_vol  = 16'h00FF;
    mix_if.ch_mute = 4'b0010;
    strobe(1);
    wait_done();
    check("d_mute", mix_if.d, 8'h44);
    check("clip_mute", mix_if.clip, 0);

    // Assorted mixes over all channels.
    for (int n = 0; n < 8; n++) begin
      mix_if.ch_data = $urandom;
      mix_if.ch_vol  = 16'($urandom);
      mix_if.ch_mute = 4'($urandom);
      strobe(1);
      wait_done();
    end

    // Overrun mid-pass; inputs scrambled after the latch edge.
    mix_if.ch_mute = '0;
    clear_flags();
    mix_if.ch_data = 32'h0000_0010;
    mix_if.ch_vol  = 16'h0008;
    strobe(1);
    tick();
    mix_if.ce_sample = 1'b1;
    mix_if.ch_data   = $urandom;
    mix_if.ch_vol    = 16'($urandom);
    tick();
    mix_if.ce_sample = 1'b0;
    check("overrun_set", mix_if.overrun, 1);
    wait_done();
    check("d_overrun_pass", mix_if.d, 8'h88);
    for (int k = 0; k < 6; k++) tick();

    // Strobe in the OUT cycle (with a coincident clear) is refused; next edge accepted.
    clear_flags();
    check("overrun_clr", mix_if.overrun, 0);
    mix_if.ch_data = 32'h0000_0010;
    mix_if.ch_vol  = 16'h0008;
    strobe(1);
    for (int k = 0; k < CH; k++) tick();
    mix_if.ce_sample = 1'b1;
    mix_if.clr_flags = 1'b1;
    tick();
    mix_if.clr_flags = 1'b0;
    check("overrun_out_cycle", mix_if.overrun, 1);
    check("busy_after_out", mix_if.busy, 0);
    mix_if.ch_data = 32'h0000_00C0;
    mix_if.ch_vol  = 16'h000F;
    strobe(1);
    check("busy_reaccept", mix_if.busy, 1);
    wait_done();
    check("d_reaccept", mix_if.d, 8'h44);
    check("overrun_sticky", mix_if.overrun, 1);

    // Reset mid-pass aborts without d_valid.
    mix_if.ch_data = 32'h0000_0040;
    strobe(0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_d", mix_if.d, 8'h80);
    check("midrst_busy", mix_if.busy, 0);
    check("midrst_dv", mix_if.d_valid, 0);
    check("midrst_overrun", mix_if.overrun, 0);
    for (int k = 0; k < 8; k++) tick();
    strobe(1);
    wait_done();
    check("d_after_rst", mix_if.d, 8'hBC);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
